// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Owns the read and write ports of the data-memory BSRAM, which has a
//   1-cycle registered read. It shares them between the CPU, the button
//   controller (writes only) and the rect copy controller (reads only).
//   A copy window moves ownership away from the CPU. One DRAIN cycle on
//   entry and one HANDBACK cycle on exit let the last in-flight read of the
//   previous owner return to the right requester. A saturating counter
//   flags copy windows that exceed COPY_MAX_CYCLES.
//
// Ports
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_copy                         copy window request (level)
//   i_cpu_re/raddr                 CPU read request
//   i_cpu_we/waddr/wdata           CPU write request
//   o_cpu_rdata/rvalid/stall       CPU read return and stall
//   i_bc_we/waddr/wdata            button controller write request
//   i_rc_re/raddr                  rect copy read request
//   o_rc_rdata/rvalid              rect copy read return
//   o_mem_raddr, i_mem_rdata       BSRAM read port
//   o_mem_we/waddr/wdata           BSRAM write port
//   o_overrun                      sticky copy-window budget overrun
//
// state      | meaning
// -----------+-------------------------------------------------------
// S_CPU_OWN  | CPU owns both ports, no stall
// S_DRAIN    | one cycle: the last CPU read returns, no accesses
// S_COPY_OWN | RC owns the read port, BC owns the write port
// S_HANDBACK | one cycle: the last RC read returns, no accesses

module data_mem_arbiter #(
    parameter int DATA_ADDR_WIDTH = 10,
    parameter int COPY_MAX_CYCLES = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_copy,
    input  logic                       i_cpu_re,
    input  logic [DATA_ADDR_WIDTH-1:0] i_cpu_raddr,
    input  logic                       i_cpu_we,
    input  logic [DATA_ADDR_WIDTH-1:0] i_cpu_waddr,
    input  logic [15:0]                i_cpu_wdata,
    output logic [15:0]                o_cpu_rdata,
    output logic                       o_cpu_rvalid,
    output logic                       o_cpu_stall,
    input  logic                       i_bc_we,
    input  logic [DATA_ADDR_WIDTH-1:0] i_bc_waddr,
    input  logic [15:0]                i_bc_wdata,
    input  logic                       i_rc_re,
    input  logic [DATA_ADDR_WIDTH-1:0] i_rc_raddr,
    output logic [15:0]                o_rc_rdata,
    output logic                       o_rc_rvalid,
    output logic [DATA_ADDR_WIDTH-1:0] o_mem_raddr,
    input  logic [15:0]                i_mem_rdata,
    output logic                       o_mem_we,
    output logic [DATA_ADDR_WIDTH-1:0] o_mem_waddr,
    output logic [15:0]                o_mem_wdata,
    output logic                       o_overrun
);

    localparam int CW = $clog2(COPY_MAX_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(COPY_MAX_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(COPY_MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_CPU_OWN  = 2'd0,
        S_DRAIN    = 2'd1,
        S_COPY_OWN = 2'd2,
        S_HANDBACK = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_copy_cnt;
    logic            r_overrun;
    logic            r_cpu_rd_pend;
    logic            r_rc_rd_pend;
    logic            w_cpu_rd_acc;
    logic            w_rc_rd_acc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_CPU_OWN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CPU_OWN:  if (i_copy)  w_state_nxt = S_DRAIN;
            S_DRAIN:                 w_state_nxt = S_COPY_OWN;
            S_COPY_OWN: if (!i_copy) w_state_nxt = S_HANDBACK;
            S_HANDBACK:              w_state_nxt = S_CPU_OWN;
            default:                 w_state_nxt = S_CPU_OWN;
        endcase
    end

    // Port grants. i_rst_n is folded in because the state register only
    // reaches CPU_OWN once reset is asserted, and during reset the memory
    // must not be written and the CPU must stay stalled.
    always_comb begin
        o_mem_we     = 1'b0;
        o_mem_waddr  = i_cpu_waddr;
        o_mem_wdata  = i_cpu_wdata;
        o_mem_raddr  = i_cpu_raddr;
        o_cpu_stall  = 1'b1;
        w_cpu_rd_acc = 1'b0;
        w_rc_rd_acc  = 1'b0;
        case (r_state)
            S_CPU_OWN: begin
                o_cpu_stall  = ~i_rst_n;
                o_mem_we     = i_cpu_we & i_rst_n;
                w_cpu_rd_acc = i_cpu_re;
            end
            S_COPY_OWN: begin
                o_mem_we     = i_bc_we & i_rst_n;
                o_mem_waddr  = i_bc_waddr;
                o_mem_wdata  = i_bc_wdata;
                o_mem_raddr  = i_rc_raddr;
                w_rc_rd_acc  = i_rc_re;
            end
            default: ;
        endcase
    end

    // Each read carries its owner with it for one cycle. The returning
    // rvalid therefore never depends on the state at return time.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cpu_rd_pend <= 1'b0;
            r_rc_rd_pend  <= 1'b0;
        end else begin
            r_cpu_rd_pend <= w_cpu_rd_acc;
            r_rc_rd_pend  <= w_rc_rd_acc;
        end
    end

    assign o_cpu_rvalid = r_cpu_rd_pend;
    assign o_rc_rvalid  = r_rc_rd_pend;
    assign o_cpu_rdata  = i_mem_rdata;
    assign o_rc_rdata   = i_mem_rdata;

    // The count is the number of DRAIN/COPY_OWN cycles in the current window.
    // overrun is set on the cycle the count reaches the budget.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_copy_cnt <= '0;
            r_overrun  <= 1'b0;
        end else if ((r_state == S_CPU_OWN) && i_copy) begin
            r_copy_cnt <= '0;
        end else if ((r_state == S_DRAIN) || (r_state == S_COPY_OWN)) begin
            if (r_copy_cnt != CNT_MAX) begin
                r_copy_cnt <= r_copy_cnt + 1'b1;
            end
            if (r_copy_cnt == CNT_PRE) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter. It runs directed scenarios and then
// randomized traffic. The expected values come from a cycle-level reference
// model that keeps a shadow memory. A behavioural BSRAM (read-first, 1-cycle
// read) sits on the memory ports.
module tb_data_mem_arbiter;

    localparam int AW  = 10;
    localparam int MAX = 1024;

    localparam int P_CPU  = 0;
    localparam int P_DRN  = 1;
    localparam int P_COPY = 2;
    localparam int P_HB   = 3;

    logic          clk;
    logic          rst_n;
    logic          copy;
    logic          cpu_re;
    logic [AW-1:0] cpu_raddr;
    logic          cpu_we;
    logic [AW-1:0] cpu_waddr;
    logic [15:0]   cpu_wdata;
    logic [15:0]   cpu_rdata;
    logic          cpu_rvalid;
    logic          cpu_stall;
    logic          bc_we;
    logic [AW-1:0] bc_waddr;
    logic [15:0]   bc_wdata;
    logic          rc_re;
    logic [AW-1:0] rc_raddr;
    logic [15:0]   rc_rdata;
    logic          rc_rvalid;
    logic [AW-1:0] mem_raddr;
    logic [15:0]   mem_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;
    logic          overrun;

    data_mem_arbiter #(
        .DATA_ADDR_WIDTH(AW),
        .COPY_MAX_CYCLES(MAX)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_copy       (copy),
        .i_cpu_re     (cpu_re),
        .i_cpu_raddr  (cpu_raddr),
        .i_cpu_we     (cpu_we),
        .i_cpu_waddr  (cpu_waddr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_rvalid (cpu_rvalid),
        .o_cpu_stall  (cpu_stall),
        .i_bc_we      (bc_we),
        .i_bc_waddr   (bc_waddr),
        .i_bc_wdata   (bc_wdata),
        .i_rc_re      (rc_re),
        .i_rc_raddr   (rc_raddr),
        .o_rc_rdata   (rc_rdata),
        .o_rc_rvalid  (rc_rvalid),
        .o_mem_raddr  (mem_raddr),
        .i_mem_rdata  (mem_rdata),
        .o_mem_we     (mem_we),
        .o_mem_waddr  (mem_waddr),
        .o_mem_wdata  (mem_wdata),
        .o_overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BSRAM: read-first, registered read data
    logic [15:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        mem_rdata <= mem[mem_raddr];
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // reference model state
    logic [15:0] ref_mem   [0:(1<<AW)-1];
    bit          ref_valid [0:(1<<AW)-1];
    int          m_phase;
    int          m_win;
    bit          m_ovr;
    bit          m_cpu_pend, m_rc_pend;
    bit          m_cpu_dv,   m_rc_dv;
    logic [15:0] m_cpu_data, m_rc_data;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase    = P_CPU;
        m_win      = 0;
        m_ovr      = 1'b0;
        m_cpu_pend = 1'b0;
        m_rc_pend  = 1'b0;
    endtask

    task automatic idle();
        cpu_re = 0; cpu_raddr = '0; cpu_we = 0; cpu_waddr = '0; cpu_wdata = '0;
        bc_we  = 0; bc_waddr  = '0; bc_wdata = '0;
        rc_re  = 0; rc_raddr  = '0;
    endtask

    task automatic rand_inputs();
        cpu_re    = 1'($urandom_range(0, 1));
        cpu_raddr = AW'($urandom_range(0, 15));
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_waddr = AW'($urandom_range(0, 15));
        cpu_wdata = 16'($urandom);
        bc_we     = 1'($urandom_range(0, 1));
        bc_waddr  = AW'($urandom_range(0, 15));
        bc_wdata  = 16'($urandom);
        rc_re     = 1'($urandom_range(0, 1));
        rc_raddr  = AW'($urandom_range(0, 15));
    endtask

    // Called just after a falling edge with the inputs already applied. It
    // checks outputs against the model, advances over the rising edge and
    // returns at the next falling edge.
    task automatic step();
        bit            exp_we;
        logic [AW-1:0] exp_wa;
        logic [15:0]   exp_wd;
        #1;
        exp_we = (m_phase == P_CPU)  ? cpu_we :
                 (m_phase == P_COPY) ? bc_we  : 1'b0;
        exp_wa = (m_phase == P_CPU) ? cpu_waddr : bc_waddr;
        exp_wd = (m_phase == P_CPU) ? cpu_wdata : bc_wdata;
        chk("cpu_stall", cpu_stall, (m_phase != P_CPU));
        chk("mem_we", mem_we, exp_we);
        if (exp_we) begin
            chk("mem_waddr", mem_waddr, exp_wa);
            chk("mem_wdata", mem_wdata, exp_wd);
        end
        if (m_phase == P_CPU && cpu_re)  chk("mem_raddr_cpu", mem_raddr, cpu_raddr);
        if (m_phase == P_COPY && rc_re)  chk("mem_raddr_rc",  mem_raddr, rc_raddr);
        chk("cpu_rvalid", cpu_rvalid, m_cpu_pend);
        chk("rc_rvalid",  rc_rvalid,  m_rc_pend);
        if (m_cpu_pend && m_cpu_dv) chk("cpu_rdata", cpu_rdata, m_cpu_data);
        if (m_rc_pend  && m_rc_dv)  chk("rc_rdata",  rc_rdata,  m_rc_data);
        chk("overrun", overrun, m_ovr);
        @(posedge clk);
        // reads see memory contents from before this edge's write
        m_cpu_pend = (m_phase == P_CPU) && cpu_re;
        m_cpu_data = ref_mem[cpu_raddr];
        m_cpu_dv   = ref_valid[cpu_raddr];
        m_rc_pend  = (m_phase == P_COPY) && rc_re;
        m_rc_data  = ref_mem[rc_raddr];
        m_rc_dv    = ref_valid[rc_raddr];
        if (exp_we) begin
            ref_mem[exp_wa]   = exp_wd;
            ref_valid[exp_wa] = 1'b1;
        end
        if (m_phase == P_DRN || m_phase == P_COPY) begin
            m_win++;
            if (m_win >= MAX) m_ovr = 1'b1;
        end
        case (m_phase)
            P_CPU:   if (copy) begin m_phase = P_DRN; m_win = 0; end
            P_DRN:   m_phase = P_COPY;
            P_COPY:  if (!copy) m_phase = P_HB;
            default: m_phase = P_CPU;
        endcase
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_valid[i] = 1'b0;
        model_reset();
        idle();
        copy  = 1'b0;
        rst_n = 1'b0;
        cpu_we = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_stall",  cpu_stall,  1'b1);
        chk("rst_mem_we", mem_we,     1'b0);
        chk("rst_cpu_rv", cpu_rvalid, 1'b0);
        chk("rst_rc_rv",  rc_rvalid,  1'b0);
        chk("rst_ovr",    overrun,    1'b0);
        rst_n = 1'b1;
        idle();

        // CPU read with a write of the same address in the same cycle
        cpu_we = 1; cpu_waddr = AW'(16'h010); cpu_wdata = 16'hBEEF; step();
        idle(); cpu_we = 1; cpu_waddr = AW'(16'h100); cpu_wdata = 16'hCAFE; step();
        idle(); cpu_re = 1; cpu_raddr = AW'(16'h010); step();
        chk("t1_cpu_rv", cpu_rvalid, 1'b1);
        chk("t1_rdata",  cpu_rdata,  16'hBEEF);
        chk("t1_rc_rv",  rc_rvalid,  1'b0);
        idle(); cpu_re = 1; cpu_raddr = AW'(16'h010);
        cpu_we = 1; cpu_waddr = AW'(16'h010); cpu_wdata = 16'h1111; step();
        chk("rfirst_old", cpu_rdata, 16'hBEEF);
        idle(); cpu_re = 1; cpu_raddr = AW'(16'h010); step();
        chk("rfirst_new", cpu_rdata, 16'h1111);

        // copy rises with a CPU read in the same cycle
        idle(); copy = 1; cpu_re = 1; cpu_raddr = AW'(16'h100); step();
        chk("t2_cpu_rv",  cpu_rvalid, 1'b1);
        chk("t2_rdata",   cpu_rdata,  16'hCAFE);
        chk("t2_stall",   cpu_stall,  1'b1);
        idle(); rc_re = 1; rc_raddr = AW'(16'h010); cpu_re = 1; step();
        chk("t2_drain_rc", rc_rvalid, 1'b0);

        // COPY_OWN: BC write and RC read in the same cycle, CPU write ignored
        idle(); bc_we = 1; bc_waddr = AW'(16'h1F0); bc_wdata = 16'h1234;
        rc_re = 1; rc_raddr = AW'(16'h100);
        cpu_we = 1; cpu_waddr = AW'(16'h020); cpu_wdata = 16'hDEAD;
        #1;
        chk("t3_mem_we", mem_we,    1'b1);
        chk("t3_waddr",  mem_waddr, AW'(16'h1F0));
        chk("t3_wdata",  mem_wdata, 16'h1234);
        chk("t3_raddr",  mem_raddr, AW'(16'h100));
        step();
        chk("t3_rc_rv",  rc_rvalid, 1'b1);
        chk("t3_rdata",  rc_rdata,  16'hCAFE);

        // copy falls with an RC read on the last COPY_OWN cycle
        idle(); copy = 0; rc_re = 1; rc_raddr = AW'(16'h1F0); step();
        chk("t4_rc_rv",  rc_rvalid, 1'b1);
        chk("t4_rdata",  rc_rdata,  16'h1234);
        chk("t4_stall1", cpu_stall, 1'b1);
        idle(); step();
        chk("t4_stall2", cpu_stall, 1'b0);

        // randomized traffic with short copy windows
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            if ($urandom_range(0, 5) == 0) copy = ~copy;
            step();
        end
        copy = 0;
        for (int i = 0; i < 3; i++) begin rand_inputs(); step(); end

        // long window overruns the budget
        copy = 1;
        for (int i = 0; i < 1030; i++) begin rand_inputs(); step(); end
        chk("t5_ovr_set", overrun, 1'b1);
        copy = 0;
        for (int i = 0; i < 3; i++) begin rand_inputs(); step(); end
        chk("t5_ovr_hold", overrun, 1'b1);
        copy = 1;
        for (int i = 0; i < 10; i++) begin rand_inputs(); step(); end
        copy = 0;
        for (int i = 0; i < 3; i++) begin rand_inputs(); step(); end
        chk("t5_ovr_sticky", overrun, 1'b1);

        // asynchronous reset inside a copy window with an RC read pending
        idle(); copy = 1; step(); step();
        rc_re = 1; rc_raddr = AW'(16'h100); step();
        bc_we = 1; bc_waddr = AW'(16'h005); cpu_we = 1; rc_re = 1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_mem_we", mem_we,    1'b0);
        chk("t6_stall",  cpu_stall, 1'b1);
        chk("t6_rc_rv",  rc_rvalid, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); copy = 0;
        step();
        chk("t6_post_stall", cpu_stall, 1'b0);
        chk("t6_post_ovr",   overrun,   1'b0);

        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            if ($urandom_range(0, 5) == 0) copy = ~copy;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
